// File: rtl/gpu_isa_pkg.sv
// Shared instruction-set definitions for the controller and the memory-side receiver.
package gpu_isa_pkg;

  localparam int INSTRUCTION_WIDTH = 32;

  // Field positions use MSB-first indexing, so bit 0 is the instruction MSB.
  localparam int OP_MSB  = 0;
  localparam int OP_LSB  = 3;
  localparam int A_MSB   = 4;
  localparam int A_LSB   = 7;
  localparam int IMM_MSB = 8;
  localparam int IMM_LSB = 23;
  localparam int B_MSB   = 24;
  localparam int B_LSB   = 27;
  localparam int C_MSB   = 28;
  localparam int C_LSB   = 31;
  localparam int IMM_W   = IMM_LSB - IMM_MSB + 1;

  typedef enum logic [3:0] {
    OP_NOP    = 4'b0000,
    OP_ADD    = 4'b0001,
    OP_SUB    = 4'b0010,
    OP_MUL    = 4'b0011,
    OP_ADDI   = 4'b0100,
    OP_MULI   = 4'b0101,
    OP_SMA    = 4'b0110,
    OP_LOADI  = 4'b0111,
    OP_SENDL  = 4'b1000,
    OP_JMP    = 4'b1001,
    OP_WRITEB = 4'b1010,
    OP_BEQ    = 4'b1011,
    OP_BNE    = 4'b1100,
    OP_HALT   = 4'b1101,
    OP_WRITE  = 4'b1110
  } opcode_e;

  function automatic logic is_mem_op(input opcode_e op);
    case (op)
      OP_SMA, OP_LOADI, OP_SENDL, OP_WRITEB, OP_WRITE: is_mem_op = 1'b1;
      default:                                          is_mem_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_instr_receiver.sv
// Memory-side receiver: decodes memory-class instructions from the controller and
// drives the data-cache port and the FMA line bus.
module mem_instr_receiver #(
  parameter int INSTRUCTION_WIDTH = gpu_isa_pkg::INSTRUCTION_WIDTH,
  parameter int DATA_CACHE_WIDTH  = 16,
  parameter int DATA_CACHE_DEPTH  = 4096,
  parameter int FMA_COUNT         = 4,
  parameter int READ_LATENCY      = 2
) (
  input  logic                                      clk_in,
  input  logic                                      rst_in,
  input  logic [0:INSTRUCTION_WIDTH-1]              instr_in,
  input  logic                                      instr_valid_in,
  output logic                                      ready_out,
  output logic                                      drop_err_out,
  output logic [$clog2(DATA_CACHE_DEPTH)-1:0]       cache_addr_out,
  output logic [3*FMA_COUNT*DATA_CACHE_WIDTH-1:0]   cache_din_out,
  output logic                                      cache_we_out,
  input  logic [3*FMA_COUNT*DATA_CACHE_WIDTH-1:0]   cache_dout_in,
  output logic [3*FMA_COUNT*DATA_CACHE_WIDTH-1:0]   fma_line_out,
  output logic                                      fma_replace_c_out,
  output logic                                      fma_valid_out,
  output logic                                      fma_strobe_out
);
  import gpu_isa_pkg::*;

  localparam int ADDR_W     = $clog2(DATA_CACHE_DEPTH);
  localparam int LINE_WORDS = 3 * FMA_COUNT;
  localparam int LINE_W     = LINE_WORDS * DATA_CACHE_WIDTH;
  localparam int CNT_W      = $clog2(READ_LATENCY + 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_READ_WAIT = 2'd2,
    ST_PRESENT   = 2'd3
  } state_e;

  opcode_e                   op_s;
  logic [3:0]                a_s;
  logic [IMM_W-1:0]          imm_s;
  logic                      mem_op_s;
  logic                      unused_fields_s;

  state_e                                       state_r;
  logic                                         ready_r;
  logic                                         drop_err_r;
  logic [ADDR_W-1:0]                            line_addr_r;
  logic [LINE_WORDS-1:0][DATA_CACHE_WIDTH-1:0]  line_buf_r;
  logic [CNT_W-1:0]                             cnt_r;
  logic [ADDR_W-1:0]                            cache_addr_r;
  logic [LINE_W-1:0]                            cache_din_r;
  logic                                         cache_we_r;
  logic [LINE_W-1:0]                            fma_line_r;
  logic                                         replace_c_r;
  logic                                         fma_valid_r;
  logic                                         fma_strobe_r;
  logic                                         pend_replace_c_r;
  logic                                         pend_fma_valid_r;

  assign op_s     = opcode_e'(instr_in[OP_MSB:OP_LSB]);
  assign a_s      = instr_in[A_MSB:A_LSB];
  assign imm_s    = instr_in[IMM_MSB:IMM_LSB];
  assign mem_op_s = is_mem_op(op_s);
  // Only the LSBs of a and b act as flags; the c field has no meaning here.
  assign unused_fields_s = ^{instr_in[B_MSB:B_LSB-1], instr_in[C_MSB:C_LSB]};

  assign ready_out         = ready_r;
  assign drop_err_out      = drop_err_r;
  assign cache_addr_out    = cache_addr_r;
  assign cache_din_out     = cache_din_r;
  assign cache_we_out      = cache_we_r;
  assign fma_line_out      = fma_line_r;
  assign fma_replace_c_out = replace_c_r;
  assign fma_valid_out     = fma_valid_r;
  assign fma_strobe_out    = fma_strobe_r;

  // Instruction decode, line buffer and cache/FMA sequencing.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r          <= ST_IDLE;
      ready_r          <= 1'b1;
      drop_err_r       <= 1'b0;
      line_addr_r      <= '0;
      line_buf_r       <= '0;
      cnt_r            <= '0;
      cache_addr_r     <= '0;
      cache_din_r      <= '0;
      cache_we_r       <= 1'b0;
      fma_line_r       <= '0;
      replace_c_r      <= 1'b0;
      fma_valid_r      <= 1'b0;
      fma_strobe_r     <= 1'b0;
      pend_replace_c_r <= 1'b0;
      pend_fma_valid_r <= 1'b0;
    end else begin
      cache_we_r   <= 1'b0;
      fma_strobe_r <= 1'b0;
      if (instr_valid_in && !ready_r && mem_op_s) begin
        drop_err_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (instr_valid_in && ready_r) begin
            case (op_s)
              OP_SMA: line_addr_r <= imm_s[ADDR_W-1:0];
              OP_LOADI: begin
                if (int'(a_s) < LINE_WORDS) begin
                  line_buf_r[a_s] <= DATA_CACHE_WIDTH'(imm_s);
                end
              end
              OP_SENDL: begin
                cache_addr_r <= line_addr_r;
                cache_din_r  <= line_buf_r;
                cache_we_r   <= 1'b1;
                ready_r      <= 1'b0;
                state_r      <= ST_SEND;
              end
              OP_WRITEB: begin
                cache_addr_r     <= imm_s[ADDR_W-1:0];
                pend_replace_c_r <= instr_in[A_LSB];
                pend_fma_valid_r <= instr_in[B_LSB];
                cnt_r            <= '0;
                ready_r          <= 1'b0;
                state_r          <= ST_READ_WAIT;
              end
              OP_WRITE: begin
                fma_line_r   <= line_buf_r;
                replace_c_r  <= instr_in[A_LSB];
                fma_valid_r  <= instr_in[B_LSB];
                fma_strobe_r <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        ST_SEND: begin
          ready_r <= 1'b1;
          state_r <= ST_IDLE;
        end
        ST_READ_WAIT: begin
          // Address went out on entry, so read data is valid after READ_LATENCY cycles.
          if (cnt_r == CNT_W'(READ_LATENCY)) begin
            fma_line_r   <= cache_dout_in;
            replace_c_r  <= pend_replace_c_r;
            fma_valid_r  <= pend_fma_valid_r;
            fma_strobe_r <= 1'b1;
            state_r      <= ST_PRESENT;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_PRESENT: begin
          ready_r <= 1'b1;
          state_r <= ST_IDLE;
        end
        default: begin
          ready_r <= 1'b1;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_instr_receiver.sv
// Self-checking bench for mem_instr_receiver: directed scenarios followed by random
// instruction traffic, compared each cycle against a transaction-level model.
module tb_mem_instr_receiver;

  localparam int LW     = 12;
  localparam int DW     = 16;
  localparam int LINE_W = LW * DW;
  localparam int AW     = 12;
  localparam int RL     = 2;

  localparam logic [3:0] NOP    = 4'b0000;
  localparam logic [3:0] ADDI   = 4'b0100;
  localparam logic [3:0] SMA    = 4'b0110;
  localparam logic [3:0] LOADI  = 4'b0111;
  localparam logic [3:0] SENDL  = 4'b1000;
  localparam logic [3:0] WRITEB = 4'b1010;
  localparam logic [3:0] WRITE  = 4'b1110;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic [0:31]       instr_in;
  logic              instr_valid_in;
  logic              ready_out;
  logic              drop_err_out;
  logic [AW-1:0]     cache_addr_out;
  logic [LINE_W-1:0] cache_din_out;
  logic              cache_we_out;
  logic [LINE_W-1:0] cache_dout_in;
  logic [LINE_W-1:0] fma_line_out;
  logic              fma_replace_c_out;
  logic              fma_valid_out;
  logic              fma_strobe_out;

  always #5 clk_in = ~clk_in;

  mem_instr_receiver dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .instr_in          (instr_in),
    .instr_valid_in    (instr_valid_in),
    .ready_out         (ready_out),
    .drop_err_out      (drop_err_out),
    .cache_addr_out    (cache_addr_out),
    .cache_din_out     (cache_din_out),
    .cache_we_out      (cache_we_out),
    .cache_dout_in     (cache_dout_in),
    .fma_line_out      (fma_line_out),
    .fma_replace_c_out (fma_replace_c_out),
    .fma_valid_out     (fma_valid_out),
    .fma_strobe_out    (fma_strobe_out)
  );

  // Read-first data cache with a two-stage read pipeline.
  logic [LINE_W-1:0] bram [0:4095];
  logic [LINE_W-1:0] rd1, rd2;
  always @(posedge clk_in) begin
    if (cache_we_out) bram[cache_addr_out] <= cache_din_out;
    rd1 <= bram[cache_addr_out];
    rd2 <= rd1;
  end
  assign cache_dout_in = rd2;

  int checks, errors, cyc;

  // Reference model state.
  logic [DW-1:0]     m_buf [LW];
  logic [AW-1:0]     m_line_addr, m_addr;
  logic              m_err, m_rc, m_fv, p_rc, p_fv, din_chk;
  logic [LINE_W-1:0] m_din, m_line, p_line;
  logic [LINE_W-1:0] m_mem [int];
  int                ready_at, we_at, strobe_at;

  function automatic logic [LINE_W-1:0] init_line(input int addr);
    logic [LINE_W-1:0] l;
    l = '0;
    for (int i = 0; i < LW; i++)
      l[i*DW +: DW] = (addr == 7) ? 16'(i + 1) : 16'(addr * 31 + i * 257 + 3);
    return l;
  endfunction

  function automatic logic [LINE_W-1:0] mem_line(input int addr);
    return m_mem.exists(addr) ? m_mem[addr] : init_line(addr);
  endfunction

  function automatic logic [LINE_W-1:0] pack_buf();
    logic [LINE_W-1:0] l;
    l = '0;
    for (int i = 0; i < LW; i++) l[i*DW +: DW] = m_buf[i];
    return l;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LW; i++) m_buf[i] = 16'h0000;
    m_line_addr = '0; m_addr = '0; m_err = 1'b0;
    m_rc = 1'b0; m_fv = 1'b0; p_rc = 1'b0; p_fv = 1'b0;
    m_din = '0; m_line = '0; p_line = '0;
    ready_at = 0; we_at = -1; strobe_at = -1;
  endtask

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp_v);
    end
  endtask

  // Drive one cycle, advance the model, and compare every output after the edge.
  task automatic tick(input logic rst, input logic v, input logic [3:0] op,
                      input logic [3:0] a, input logic [15:0] imm, input logic [3:0] b);
    int t;
    rst_in         = rst;
    instr_valid_in = v & ~rst;
    instr_in       = {op, a, imm, b, 4'($urandom_range(0, 15))};
    @(posedge clk_in);
    #1;
    t = cyc;
    cyc++;
    din_chk = 1'b0;
    if (rst) begin
      model_reset();
      din_chk = 1'b1;
    end else if (v) begin
      if (t >= ready_at) begin
        case (op)
          SMA:   m_line_addr = imm[AW-1:0];
          LOADI: if (a < 4'(LW)) m_buf[a] = imm;
          SENDL: begin
            m_addr = m_line_addr;
            m_din  = pack_buf();
            m_mem[int'(m_line_addr)] = m_din;
            we_at    = t + 1;
            ready_at = t + 2;
          end
          WRITEB: begin
            m_addr    = imm[AW-1:0];
            p_line    = mem_line(int'(imm[AW-1:0]));
            p_rc      = a[0];
            p_fv      = b[0];
            strobe_at = t + 2 + RL;
            ready_at  = t + 3 + RL;
          end
          WRITE: begin
            p_line    = pack_buf();
            p_rc      = a[0];
            p_fv      = b[0];
            strobe_at = t + 1;
          end
          default: ;
        endcase
      end else if (op inside {SMA, LOADI, SENDL, WRITEB, WRITE}) begin
        m_err = 1'b1;
      end
    end
    if (cyc == strobe_at) begin
      m_line = p_line; m_rc = p_rc; m_fv = p_fv;
    end
    chk("ready", ready_out, cyc >= ready_at);
    chk("drop_err", drop_err_out, m_err);
    chk("cache_we", cache_we_out, cyc == we_at);
    chk("cache_addr", cache_addr_out, m_addr);
    if (din_chk || cyc == we_at) chk("cache_din", cache_din_out, m_din);
    chk("fma_strobe", fma_strobe_out, cyc == strobe_at);
    chk("fma_line", fma_line_out, m_line);
    chk("replace_c", fma_replace_c_out, m_rc);
    chk("fma_valid", fma_valid_out, m_fv);
    chk("line_addr", dut.line_addr_r, m_line_addr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, NOP, 4'h0, 16'h0000, 4'h0);
  endtask

  initial begin
    logic [3:0] rop;
    for (int i = 0; i < 4096; i++) bram[i] <= init_line(i);
    checks = 0; errors = 0; cyc = 0;
    rst_in = 1'b1; instr_valid_in = 1'b0; instr_in = '0;
    model_reset();

    tick(1'b1, 1'b0, NOP, 4'h0, 16'h0000, 4'h0);
    idle(1);
    tick(1'b0, 1'b1, SMA, 4'h0, 16'h0005, 4'h0);
    idle(2);

    tick(1'b0, 1'b1, LOADI, 4'd0,  16'h1234, 4'h0);
    tick(1'b0, 1'b1, LOADI, 4'd11, 16'hBEEF, 4'h0);
    tick(1'b0, 1'b1, LOADI, 4'd12, 16'hFFFF, 4'h0);
    tick(1'b0, 1'b1, SENDL, 4'h0,  16'h0000, 4'h0);
    idle(3);

    tick(1'b0, 1'b1, WRITEB, 4'd1, 16'h0007, 4'd1);
    tick(1'b0, 1'b1, ADDI,   4'd3, 16'h0042, 4'd2);
    idle(4);

    tick(1'b0, 1'b1, SENDL, 4'h0, 16'h0000, 4'h0);
    tick(1'b0, 1'b1, LOADI, 4'd0, 16'hAAAA, 4'h0);
    idle(2);

    tick(1'b0, 1'b1, LOADI, 4'd2, 16'h5A5A, 4'h0);
    tick(1'b0, 1'b1, WRITE, 4'd0, 16'h0000, 4'd0);
    idle(1);

    tick(1'b0, 1'b1, WRITEB, 4'd1, 16'h0009, 4'd1);
    idle(1);
    tick(1'b1, 1'b0, NOP, 4'h0, 16'h0000, 4'h0);
    idle(5);

    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 9))
        0: rop = SMA;
        1: rop = LOADI;
        2: rop = SENDL;
        3: rop = WRITEB;
        4: rop = WRITE;
        default: rop = 4'($urandom_range(0, 15));
      endcase
      tick(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), rop,
           4'($urandom_range(0, 15)), 16'($urandom), 4'($urandom_range(0, 15)));
    end
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_instr_receiver.md
# mem_instr_receiver

Memory-side receiver for the controller's instruction stream. Accepts the 32-bit instructions the controller broadcasts and decodes the memory-class opcodes. It maintains the current line address and a temporary line register, and drives the data-cache BRAM port and the FMA write bus. It sits between the controller and the data cache / FMA array, inside the memory subsystem.

## Interface
Parameters:
- `INSTRUCTION_WIDTH`, 32, instruction bits, MSB-first indexing `[0:31]`.
- `DATA_CACHE_WIDTH`, 16, bits per fixed-point word.
- `DATA_CACHE_DEPTH`, 4096, lines in the data cache; `ADDR_W = $clog2(DATA_CACHE_DEPTH)`.
- `FMA_COUNT`, 4, FMA blocks; a line holds `LINE_WORDS = 3*FMA_COUNT` words (a,b,c per FMA).
- `READ_LATENCY`, 2, data-cache read latency in cycles.

Ports:
- `clk_in` in 1: clock.
- `rst_in` in 1: reset. One clock; reset is synchronous and active-high.
- `instr_in` in `[0:31]`: instruction word.
- `instr_valid_in` in 1: one-cycle strobe per instruction.
- `ready_out` out 1: high when a new instruction can be accepted.
- `drop_err_out` out 1: sticky; set when a memory-class instruction arrives while `ready_out`=0.
- `cache_addr_out` out `ADDR_W`: data-cache address.
- `cache_din_out` out `LINE_WORDS*DATA_CACHE_WIDTH`: write data (word 0 in LSBs).
- `cache_we_out` out 1: write enable.
- `cache_dout_in` in `LINE_WORDS*DATA_CACHE_WIDTH`: read data.
- `fma_line_out` out `LINE_WORDS*DATA_CACHE_WIDTH`: line to FMAs; FMA i uses words 3i, 3i+1, 3i+2 as a, b, c.
- `fma_replace_c_out` out 1: FMAs take c from the line.
- `fma_valid_out` out 1: FMAs emit a result.
- `fma_strobe_out` out 1: one-cycle qualifier for the three `fma_*` outputs.

## Operation
- Field layout: op=`[0:3]`, a=`[4:7]`, imm=`[8:23]`, b=`[24:27]`, c=`[28:31]`.
- An instruction is accepted when `instr_valid_in` && `ready_out`.
- SMA (0110): `line_addr <= imm[ADDR_W-1:0]`.
- LOADI (0111): `line_buf[a] <= imm`. Index `a >= LINE_WORDS` is ignored.
- SENDL (1000): writes `line_buf` to `line_addr`.
- WRITEB (1010): reads line `imm` and presents it to the FMAs. `replace_c` = `a[3]` (LSB of a), `fma_valid` = `b[3]`.
- WRITE (1110): presents `line_buf` directly, with the same flag rules as WRITEB.
- NOP and every other opcode (controller-only or unimplemented) are ignored. They never set `drop_err_out` and never change state.
- States:
  - IDLE: `ready_out`=1.
  - SEND: one cycle, `cache_we_out`=1, then IDLE.
  - READ_WAIT: `READ_LATENCY` cycles, counter-driven.
  - PRESENT: one cycle, latch `cache_dout_in` into `fma_line_out`, then IDLE.
- A memory-class instruction arriving outside IDLE is dropped and sets `drop_err_out`. State is unchanged.
- LOADI and SMA do not modify an in-flight SENDL/WRITEB. Nothing is accepted while busy.

## Timing
- Reset: every output is 0 except `ready_out`=1. `line_addr`, `line_buf`, the counter and `drop_err_out` clear to 0.
- SMA/LOADI accepted at cycle T: the new value is visible at T+1. The block stays ready, so back-to-back acceptance is allowed.
- SENDL at T:
  - At T+1, `cache_we_out`=1, with `cache_addr_out`=`line_addr` and `cache_din_out`=`line_buf`.
  - `ready_out`=0 at T+1; back to 1 at T+2.
- WRITEB at T:
  - `cache_addr_out`=imm from T+1.
  - `cache_dout_in` is sampled at T+1+`READ_LATENCY`.
  - `fma_strobe_out`=1 at T+2+`READ_LATENCY` (T+4 by default).
  - `ready_out`=0 from T+1 through T+2+`READ_LATENCY`; back to 1 the next cycle.
- WRITE at T: `fma_strobe_out`=1 at T+1 with `line_buf` as of T (before any same-cycle update). `ready_out` stays 1.
- `fma_line_out` and the flags hold their values between strobes.
- `cache_we_out` is 0 outside SEND; `cache_addr_out` holds its last value.
- Reset mid-SEND or mid-READ_WAIT aborts the operation. No write or strobe occurs after the reset cycle.

## Structure
- Shared package `gpu_isa_pkg` holds:
  - the opcode enum (all 15 controller opcodes);
  - field-slice localparams (OP_MSB/LSB etc.);
  - `INSTRUCTION_WIDTH`.
- The controller is to import the same package.
- No sub-module is needed. The data-cache BRAM (`xilinx_true_dual_port_read_first_2_clock_ram`, HIGH_PERFORMANCE) is instantiated by the parent.

## Test plan
- Reset, then SMA imm=0x0005 → at T+1, `line_addr`=5; `ready_out` stays 1 and all other outputs stay 0.
- LOADI a=0 imm=0x1234, LOADI a=11 imm=0xBEEF, LOADI a=12 imm=0xFFFF, then SENDL → one `cache_we_out` pulse at address 5:
  - word0=0x1234, word11=0xBEEF;
  - the a=12 write is ignored;
  - `ready_out` is low for exactly 1 cycle.
- Preload BRAM model line 7 = words 1..12; WRITEB imm=7 a=1 b=1 → `fma_strobe_out` at T+4 with `fma_line_out` = that line, `replace_c`=1, `fma_valid`=1; ready is low T+1..T+4.
- SENDL immediately followed by LOADI (next cycle) → LOADI is dropped, `drop_err_out`=1 (sticky), `line_buf` unchanged; an ADDI during busy leaves the flag unaffected.
- WRITE a=0 b=0 in the same cycle a prior LOADI result lands → the strobe presents the updated buffer, with `replace_c`=0 and `fma_valid`=0.
- Assert `rst_in` at T+2 of a WRITEB → no `fma_strobe_out`; `ready_out`=1 and all outputs are 0 after reset.
